// File: rtl/dmem_access_unit_pkg.sv
// Shared encodings for the data-memory access path: load/store size codes
// (also produced by the main control decoder) and the access FSM states.
package dmem_access_unit_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_WORD = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_HALF = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Words need a 4-byte boundary, halves a 2-byte boundary, bytes go anywhere.
    function automatic logic is_aligned(input size_e size, input logic [1:0] offset);
        logic ok;
        ok = 1'b1;
        case (size)
            SZ_WORD: ok = (offset == 2'b00);
            SZ_HALF: ok = ~offset[0];
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Word-wide data-memory bus: request held until a one-cycle ack strobe.
interface dmem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between a sub-word access and the little-endian 32-bit
// bus: store byte enables, replicated store data and sign-extended load data.
module dmem_lane_align
    import dmem_access_unit_pkg::*;
(
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] store_data,
    output logic [31:0] load_data
);

    logic [31:0] lane;

    assign lane = bus_rdata >> {offset, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        be         = 4'b0000;
        store_data = 32'h0;
        load_data  = 32'h0;
        case (size)
            SZ_WORD: begin
                be         = 4'b1111;
                store_data = wdata;
                load_data  = lane;
            end
            SZ_HALF: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                store_data = {2{wdata[15:0]}};
                load_data  = {{16{lane[15]}}, lane[15:0]};
            end
            SZ_BYTE: begin
                be         = 4'b0001 << offset;
                store_data = {4{wdata[7:0]}};
                load_data  = {{24{lane[7]}}, lane[7:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory access unit: turns load/store size codes into one
// word-aligned bus transaction, stalling the pipeline until ack or timeout.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mem_read,
    input  logic [1:0]           mem_write,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          load_data,
    output logic                 stall,
    output logic                 misalign,
    output logic                 bus_err,
    dmem_access_unit_if.master   bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    size_e             size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       ld_q, ld_d;

    logic        req_any;
    logic        req_we;
    size_e       req_size;
    logic        req_ok;
    logic        start;
    logic        legal_start;
    logic        timeout;
    logic        busy;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;

    // A write takes priority when the decoder flags both directions.
    assign req_we   = (mem_write != SZ_NONE);
    assign req_any  = req_we || (mem_read != SZ_NONE);
    assign req_size = size_e'(req_we ? mem_write : mem_read);
    assign req_ok   = is_aligned(req_size, addr[1:0]);

    // Gated by rst_n so stall and misalign read 0 while reset is held.
    assign start       = rst_n && (state_q == ST_IDLE) && req_any;
    assign legal_start = start && req_ok;
    assign busy        = (state_q == ST_BUSY);
    assign timeout     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    dmem_lane_align u_lane_align (
        .size       (size_q),
        .offset     (addr_q[1:0]),
        .wdata      (wdata_q),
        .bus_rdata  (bus.bus_rdata),
        .be         (lane_be),
        .store_data (lane_wdata),
        .load_data  (lane_load)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples the pre-edge value of its inputs.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; an ack in the timeout cycle still completes normally.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (legal_start) state_d = ST_BUSY;
            ST_BUSY: if (bus.bus_ack || timeout) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        cnt_d   = '0;
        if (legal_start) begin
            we_d    = req_we;
            size_d  = req_size;
            addr_d  = addr;
            wdata_d = wdata;
        end
        if (busy) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            if (bus.bus_ack) ld_d = lane_load;
            else if (timeout) ld_d = 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_NONE;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            ld_q    <= 32'h0;
        end else begin
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
        end
    end

    // Output logic; bus drives only from latched values and only while BUSY.
    always_comb begin
        stall         = legal_start || busy;
        misalign      = start && !req_ok;
        bus_err       = busy && !bus.bus_ack && timeout;
        load_data     = (state_q == ST_DONE) ? ld_q : 32'h0;
        bus.bus_req   = busy;
        bus.bus_we    = busy && we_q;
        bus.bus_addr  = '0;
        bus.bus_be    = 4'b0000;
        bus.bus_wdata = 32'h0;
        if (busy) begin
            bus.bus_addr  = {addr_q[ADDR_W-1:2], 2'b00};
            bus.bus_be    = we_q ? lane_be : 4'b1111;
            bus.bus_wdata = we_q ? lane_wdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with TIMEOUT_CYCLES=4; each task drives
// one scenario and compares against hand-computed values.
module tb_dmem_access_unit;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mem_read;
    logic [1:0]  mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        stall;
    logic        misalign;
    logic        bus_err;

    int n_pass;
    int n_total;

    dmem_access_unit_if #(.ADDR_W(32)) bus ();

    dmem_access_unit #(
        .TIMEOUT_CYCLES (4),
        .ADDR_W         (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .load_data (load_data),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  stall_cycles;
        logic [7:0]  busy_cycles;
        logic [7:0]  err_cycle;
        logic        req_seen;
        logic        err_seen;
        logic        mis_seen;
        logic        released;
        logic        we;
        logic [3:0]  be;
        logic [31:0] baddr;
        logic [31:0] bwdata;
        logic [31:0] ld;
        logic [31:0] ld_after;
        logic        stall_after;
        logic        mis_after;
    } obs_t;

    // Runs one access from IDLE (entered at posedge+1) and records what was seen.
    // ack_at = BUSY cycle (1-based) in which the bus acks; 0 = never.
    task automatic run_access(input logic [1:0] rd, input logic [1:0] wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rdat, input int ack_at,
                              output obs_t o);
        o = '0;
        mem_read      = rd;
        mem_write     = wr;
        addr          = a;
        wdata         = wd;
        bus.bus_rdata = rdat;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.bus_req) o.busy_cycles = o.busy_cycles + 8'd1;
            bus.bus_ack = bus.bus_req && (int'(o.busy_cycles) == ack_at);
            #1;
            if (bus.bus_req && o.busy_cycles == 8'd1) begin
                o.req_seen = 1'b1;
                o.baddr    = bus.bus_addr;
                o.be       = bus.bus_be;
                o.we       = bus.bus_we;
                o.bwdata   = bus.bus_wdata;
            end
            if (stall) o.stall_cycles = o.stall_cycles + 8'd1;
            if (misalign) o.mis_seen = 1'b1;
            if (bus_err) begin
                o.err_seen  = 1'b1;
                o.err_cycle = o.busy_cycles;
            end
            if (!stall) begin
                o.released = 1'b1;
                o.ld       = load_data;
                break;
            end
            @(posedge clk);
            #1;
            bus.bus_ack = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.bus_ack = 1'b0;
        mem_read    = 2'b00;
        mem_write   = 2'b00;
        @(negedge clk);
        #1;
        o.ld_after    = load_data;
        o.stall_after = stall;
        o.mis_after   = misalign;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_read = 2'b01; mem_write = 2'b00; addr = 32'h10; wdata = 32'hFFFF_FFFF;
        bus.bus_ack = 1'b0; bus.bus_rdata = 32'h0;
        #12;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (bus.bus_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.bus_req); else n_pass++;
        n_total++; if (load_data !== 32'h0) $display("FAIL reset_load_data: got %h want 0", load_data); else n_pass++;
        n_total++; if ({misalign, bus_err, bus.bus_we, bus.bus_be} !== 7'b0) $display("FAIL reset_flags: got %b want 0", {misalign, bus_err, bus.bus_we, bus.bus_be}); else n_pass++;
        n_total++; if ({bus.bus_addr, bus.bus_wdata} !== 64'h0) $display("FAIL reset_bus: got %h want 0", {bus.bus_addr, bus.bus_wdata}); else n_pass++;
        mem_read = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_word_load();
        obs_t o;
        run_access(2'b01, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 2, o);
        n_total++; if (o.baddr !== 32'h10) $display("FAIL lw_addr: got %h want %h", o.baddr, 32'h10); else n_pass++;
        n_total++; if ({o.we, o.be} !== 5'b0_1111) $display("FAIL lw_we_be: got %b want 01111", {o.we, o.be}); else n_pass++;
        n_total++; if (o.stall_cycles !== 8'd3) $display("FAIL lw_stall_cycles: got %0d want 3", o.stall_cycles); else n_pass++;
        n_total++; if (o.ld !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want %h", o.ld, 32'hDEADBEEF); else n_pass++;
        n_total++; if (o.ld_after !== 32'h0) $display("FAIL lw_data_after_done: got %h want 0", o.ld_after); else n_pass++;
        n_total++; if (o.stall_after !== 1'b0) $display("FAIL lw_no_retrigger: got stall %b want 0", o.stall_after); else n_pass++;
    endtask

    task automatic test_sub_word_load();
        obs_t o;
        run_access(2'b10, 2'b00, 32'h13, 32'h0, 32'h80112233, 1, o);
        n_total++; if (o.ld !== 32'hFFFFFF80) $display("FAIL lb13_data: got %h want %h", o.ld, 32'hFFFFFF80); else n_pass++;
        n_total++; if ({o.baddr, o.be} !== {32'h10, 4'b1111}) $display("FAIL lb13_addr_be: got %h/%b want 10/1111", o.baddr, o.be); else n_pass++;
        n_total++; if (o.stall_cycles !== 8'd2) $display("FAIL lb13_min_latency: got %0d want 2", o.stall_cycles); else n_pass++;
        run_access(2'b10, 2'b00, 32'h12, 32'h0, 32'h80112233, 1, o);
        n_total++; if (o.ld !== 32'h00000011) $display("FAIL lb12_data: got %h want %h", o.ld, 32'h00000011); else n_pass++;
        run_access(2'b11, 2'b00, 32'h12, 32'h0, 32'h80112233, 1, o);
        n_total++; if (o.ld !== 32'hFFFF8011) $display("FAIL lh12_data: got %h want %h", o.ld, 32'hFFFF8011); else n_pass++;
        run_access(2'b11, 2'b00, 32'h10, 32'h0, 32'h80112233, 1, o);
        n_total++; if (o.ld !== 32'h00002233) $display("FAIL lh10_data: got %h want %h", o.ld, 32'h00002233); else n_pass++;
    endtask

    task automatic test_store();
        obs_t o;
        run_access(2'b00, 2'b11, 32'h22, 32'h1234ABCD, 32'h0, 1, o);
        n_total++; if ({o.we, o.baddr} !== {1'b1, 32'h20}) $display("FAIL sh_we_addr: got %b/%h want 1/20", o.we, o.baddr); else n_pass++;
        n_total++; if (o.be !== 4'b1100) $display("FAIL sh_be: got %b want 1100", o.be); else n_pass++;
        n_total++; if (o.bwdata !== 32'hABCDABCD) $display("FAIL sh_wdata: got %h want %h", o.bwdata, 32'hABCDABCD); else n_pass++;
        run_access(2'b00, 2'b10, 32'h21, 32'h000000EE, 32'h0, 1, o);
        n_total++; if ({o.be, o.baddr} !== {4'b0010, 32'h20}) $display("FAIL sb_be_addr: got %b/%h want 0010/20", o.be, o.baddr); else n_pass++;
        n_total++; if (o.bwdata !== 32'hEEEEEEEE) $display("FAIL sb_wdata: got %h want %h", o.bwdata, 32'hEEEEEEEE); else n_pass++;
        run_access(2'b00, 2'b01, 32'h04, 32'hCAFEF00D, 32'h0, 1, o);
        n_total++; if ({o.be, o.bwdata} !== {4'b1111, 32'hCAFEF00D}) $display("FAIL sw_be_wdata: got %b/%h want 1111/cafef00d", o.be, o.bwdata); else n_pass++;
        run_access(2'b01, 2'b10, 32'h23, 32'h0000005A, 32'h0, 1, o);
        n_total++; if ({o.we, o.be, o.bwdata} !== {1'b1, 4'b1000, 32'h5A5A5A5A}) $display("FAIL write_wins: got %b/%b/%h want 1/1000/5a5a5a5a", o.we, o.be, o.bwdata); else n_pass++;
    endtask

    task automatic test_misalign();
        obs_t o;
        run_access(2'b01, 2'b00, 32'h02, 32'h0, 32'h0, 1, o);
        n_total++; if ({o.mis_seen, o.req_seen, o.stall_cycles} !== {1'b1, 1'b0, 8'd0}) $display("FAIL lw02_misalign: got mis=%b req=%b stall=%0d want 1/0/0", o.mis_seen, o.req_seen, o.stall_cycles); else n_pass++;
        n_total++; if ({o.ld, o.mis_after} !== 33'h0) $display("FAIL lw02_after: got ld=%h mis=%b want 0/0", o.ld, o.mis_after); else n_pass++;
        run_access(2'b11, 2'b00, 32'h03, 32'h0, 32'h0, 1, o);
        n_total++; if ({o.mis_seen, o.req_seen, o.stall_cycles} !== {1'b1, 1'b0, 8'd0}) $display("FAIL lh03_misalign: got mis=%b req=%b stall=%0d want 1/0/0", o.mis_seen, o.req_seen, o.stall_cycles); else n_pass++;
        run_access(2'b10, 2'b00, 32'h03, 32'h0, 32'h44000000, 1, o);
        n_total++; if ({o.mis_seen, o.ld} !== {1'b0, 32'h00000044}) $display("FAIL lb03_legal: got mis=%b ld=%h want 0/44", o.mis_seen, o.ld); else n_pass++;
    endtask

    task automatic test_timeout();
        obs_t o;
        run_access(2'b01, 2'b00, 32'h30, 32'h0, 32'h0BADF00D, 4, o);
        n_total++; if ({o.err_seen, o.ld} !== {1'b0, 32'h0BADF00D}) $display("FAIL ack_beats_timeout: got err=%b ld=%h want 0/0badf00d", o.err_seen, o.ld); else n_pass++;
        run_access(2'b01, 2'b00, 32'h34, 32'h0, 32'h12345678, 0, o);
        n_total++; if ({o.err_seen, o.err_cycle} !== {1'b1, 8'd4}) $display("FAIL timeout_err: got err=%b cycle=%0d want 1/4", o.err_seen, o.err_cycle); else n_pass++;
        n_total++; if (o.ld !== 32'h0) $display("FAIL timeout_data: got %h want 0", o.ld); else n_pass++;
        n_total++; if ({o.released, o.stall_cycles} !== {1'b1, 8'd5}) $display("FAIL timeout_release: got rel=%b stall=%0d want 1/5", o.released, o.stall_cycles); else n_pass++;
    endtask

    task automatic test_stray_ack();
        bus.bus_ack = 1'b1;
        bus.bus_rdata = 32'h55555555;
        @(posedge clk);
        #1;
        bus.bus_ack = 1'b0;
        @(negedge clk);
        n_total++; if ({stall, bus.bus_req, load_data} !== 34'h0) $display("FAIL stray_ack: got stall=%b req=%b ld=%h want 0/0/0", stall, bus.bus_req, load_data); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        obs_t o;
        mem_read = 2'b01; mem_write = 2'b00; addr = 32'h40;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        n_total++; if (bus.bus_req !== 1'b1) $display("FAIL midrst_in_busy: got req %b want 1", bus.bus_req); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({bus.bus_req, stall} !== 2'b00) $display("FAIL midrst_async_drop: got req/stall %b want 00", {bus.bus_req, stall}); else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        mem_read = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_access(2'b01, 2'b00, 32'h44, 32'h0, 32'h11223344, 1, o);
        n_total++; if ({o.baddr, o.stall_cycles, o.ld} !== {32'h44, 8'd2, 32'h11223344}) $display("FAIL midrst_recover: got addr=%h stall=%0d ld=%h want 44/2/11223344", o.baddr, o.stall_cycles, o.ld); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_word_load();
        test_sub_word_load();
        test_store();
        test_misalign();
        test_timeout();
        test_stray_ack();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
